// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative MIPS I MULT/MULTU/DIV/DIVU unit owning HI/LO; one radix-2
//            step per cycle, WIDTH+2 cycle latency. Optional macro: MULDIV_ABORT_EN
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
`ifdef MULDIV_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_is_div;
  logic                   r_neg;
  logic                   r_rem_neg;
  logic                   r_div0;
  logic [WIDTH-1:0]       r_opnd;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_done;

  logic                   w_abort;
  logic                   w_accept;
  logic                   w_step;
  logic                   w_commit;
  logic                   w_wr_hi;
  logic                   w_wr_lo;

`ifdef MULDIV_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Operand conditioning at the accepting edge
  logic                   w_signed;
  logic                   w_rs_neg;
  logic                   w_rt_neg;
  logic [WIDTH-1:0]       w_rs_abs;
  logic [WIDTH-1:0]       w_rt_abs;

  assign w_signed = ~op_i[0];
  assign w_rs_neg = w_signed & rs_data_i[WIDTH-1];
  assign w_rt_neg = w_signed & rt_data_i[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -rs_data_i : rs_data_i;
  assign w_rt_abs = w_rt_neg ? -rt_data_i : rt_data_i;

  // Shift-add multiply: upper half accumulates, multiplier drains from the bottom
  logic [WIDTH:0]         w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Restoring divide: WIDTH+1 bit trial remainder, result always fits WIDTH bits
  logic [WIDTH:0]         w_trial;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_rem_nxt;
  assign w_trial   = {r_rem, r_acc[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_opnd});
  assign w_rem_nxt = w_ge ? WIDTH'(w_trial - {1'b0, r_opnd}) : w_trial[WIDTH-1:0];

  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rmd;
  logic [WIDTH-1:0]       w_res_hi;
  logic [WIDTH-1:0]       w_res_lo;

  // A zero divisor leaves an all-ones quotient that must not be sign-flipped
  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_quo    = (r_neg & ~r_div0) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd    = r_rem_neg ? -r_rem : r_rem;
  assign w_res_hi = r_is_div ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wr_hi  = mthi_i;
        w_wr_lo  = mtlo_i;
        w_accept = start_i;
        if (start_i) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_FIX;
          end
        end
      end
      S_FIX: begin
        busy_o      = 1'b1;
        w_commit    = ~w_abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_wr_hi) begin
        r_hi <= wdata_i;
      end
      if (w_wr_lo) begin
        r_lo <= wdata_i;
      end
      if (w_accept) begin
        r_cnt     <= '0;
        r_is_div  <= op_i[1];
        r_neg     <= w_rs_neg ^ w_rt_neg;
        r_rem_neg <= op_i[1] & w_rs_neg;
        r_div0    <= (rt_data_i == '0);
        r_opnd    <= op_i[1] ? w_rt_abs : w_rs_abs;
        r_acc     <= {{WIDTH{1'b0}}, (op_i[1] ? w_rs_abs : w_rt_abs)};
        r_rem     <= '0;
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
          r_rem            <= w_rem_nxt;
        end else begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end
      end
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed bench for muldiv_unit with an arithmetic reference model
//            compared every cycle. Optional macro: MULDIV_ABORT_EN
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic              clk       = 1'b0;
  logic              rst_ni    = 1'b0;
  logic              start_i   = 1'b0;
  logic [1:0]        op_i      = 2'd0;
  logic [WIDTH-1:0]  rs_data_i = '0;
  logic [WIDTH-1:0]  rt_data_i = '0;
  logic              mthi_i    = 1'b0;
  logic              mtlo_i    = 1'b0;
  logic [WIDTH-1:0]  wdata_i   = '0;
  logic              abort_i   = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic [WIDTH-1:0]  hi_o;
  logic [WIDTH-1:0]  lo_o;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .mthi_i    (mthi_i),
    .mtlo_i    (mtlo_i),
    .wdata_i   (wdata_i),
`ifdef MULDIV_ABORT_EN
    .abort_i   (abort_i),
`endif
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result {HI,LO} straight from integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return r;
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_done = 1'b0;
  logic [63:0] m_res  = '0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (mthi_i) m_hi <= wdata_i;
        if (mtlo_i) m_lo <= wdata_i;
        if (start_i) begin
          m_left <= WIDTH + 1;
          m_res  <= ref_result(op_i, rs_data_i, rt_data_i);
        end
`ifdef MULDIV_ABORT_EN
      end else if (abort_i) begin
        m_left <= 0;
`endif
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", 64'(busy_o), 64'(m_left != 0));
    check("cmp_done", 64'(done_o), 64'(m_done));
    check("cmp_hi",   64'(hi_o),   64'(m_hi));
    check("cmp_lo",   64'(lo_o),   64'(m_lo));
  end

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_o) bc++;
    end while (!done_o && lat < 100);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int lat;
    int bc;
    @(posedge clk);
    #1;
    start_i = 1'b1; op_i = op; rs_data_i = rs; rt_data_i = rt;
    @(posedge clk);
    #1;
    start_i = 1'b0; rs_data_i = '1; rt_data_i = '1;
    wait_done(lat, bc);
    check({nm, "_latency"}, 64'(lat), 64'd34);
    check({nm, "_busycyc"}, 64'(bc), 64'd33);
    check({nm, "_hi"}, 64'(hi_o), 64'(ehi));
    check({nm, "_lo"}, 64'(lo_o), 64'(elo));
  endtask

  initial begin
    int lat;
    int bc;
    int dc;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_hi",   64'(hi_o),   64'd0);
    check("reset_lo",   64'(lo_o),   64'd0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    run_op(2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");
    run_op(2'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_neg_by0");

    // start and MTHI mid-calculation must be ignored
    @(posedge clk);
    #1 start_i = 1'b1; op_i = 2'd3; rs_data_i = 32'd1000; rt_data_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 start_i = 1'b1; op_i = 2'd0; rs_data_i = 32'd5; rt_data_i = 32'd5;
    mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 start_i = 1'b0; mthi_i = 1'b0;
    wait_done(lat, bc);
    check("busy_ignore_hi", 64'(hi_o), 64'd1);
    check("busy_ignore_lo", 64'(lo_o), 64'd333);

    @(posedge clk);
    #1 mtlo_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 mtlo_i = 1'b0;
    @(negedge clk);
    check("mtlo_idle", 64'(lo_o), 64'hA5A5_A5A5);

    // start together with MTHI: write lands, op result overwrites later
    @(posedge clk);
    #1 start_i = 1'b1; op_i = 2'd1; rs_data_i = 32'd6; rt_data_i = 32'd7;
    mthi_i = 1'b1; wdata_i = 32'h1111_2222;
    @(posedge clk);
    #1 start_i = 1'b0; mthi_i = 1'b0;
    @(negedge clk);
    check("start_mthi_hi", 64'(hi_o), 64'h1111_2222);
    wait_done(lat, bc);
    check("start_mthi_res_hi", 64'(hi_o), 64'd0);
    check("start_mthi_res_lo", 64'(lo_o), 64'd42);

    // reset mid-operation
    @(posedge clk);
    #1 start_i = 1'b1; op_i = 2'd0; rs_data_i = 32'd3; rt_data_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_hi",   64'(hi_o),   64'd0);
    check("midrst_lo",   64'(lo_o),   64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) dc++;
    end
    check("midrst_no_done", 64'(dc), 64'd0);

`ifdef MULDIV_ABORT_EN
    @(posedge clk);
    #1 mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h5555_6666;
    @(posedge clk);
    #1 mthi_i = 1'b0; mtlo_i = 1'b0;
    start_i = 1'b1; op_i = 2'd1; rs_data_i = 32'd9; rt_data_i = 32'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_hi",   64'(hi_o),   64'h5555_6666);
    check("abort_lo",   64'(lo_o),   64'h5555_6666);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) dc++;
    end
    check("abort_no_done", 64'(dc), 64'd0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
